mdu_pipe_unit: RTL and testbench
================================

Name: mdu_pipe_unit

Overview:
- Parametrised multiply/divide unit holding architectural HI/LO registers for the pipelined MIPS core.
- Sits in the E stage beside the ALU and runs MULT/MULTU/DIV/DIVU over a configurable number of cycles.
- Exposes busy/done so the hazard controller can stall MFHI/MFLO and back-to-back MD ops.
- Successor to the fixed-latency P6 MDU, adding cancel, configurable width and latency, and optional accumulate.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU/MADD; must be at least 1.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  E-stage MD instruction valid this cycle.
- op  in  3  operation code: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 MADD.
- src_a  in  WIDTH  rs operand, already forwarded.
- src_b  in  WIDTH  rt operand, already forwarded.
- cancel  in  1  abort any in-flight operation; used on flush/exception.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  multi-cycle operation in flight.
- done  out  1  one-cycle pulse; HI/LO were just committed by a multi-cycle op.

Behaviour:
- Reset, while reset is 0 and asynchronously on its assertion: hi=0, lo=0, busy=0, done=0, counter=0, latched op and operands cleared. Reset mid-operation discards the operation.
- States: IDLE (counter==0) and RUN (counter!=0). busy = (counter!=0), driven from a register with no combinational path from inputs.
- Start sampled in IDLE:
  - Multi-cycle ops (001–100, and 111 when enabled) at edge t0: latch op, src_a and src_b; load counter with MULT_CYCLES or DIV_CYCLES; go to RUN. busy=1 for exactly N cycles after t0.
  - Counter decrements each edge. On the edge where counter goes 1->0: hi/lo get the result, done=1 for one cycle, busy=0 in that same cycle.
  - The new hi/lo are therefore visible exactly N cycles after t0.
  - MTHI/MTLO: hi (or lo) = src_a at the next edge. Never busy, never done.
  - NOP: no effect.
- Start while busy:
  - Ignored entirely, including MTHI/MTLO. The controller stalls all MD ops and MFHI/MFLO while (busy | start & multi-cycle op).
  - Bench asserts an error if this occurs.
- Cancel:
  - Counter cleared to 0 at the next edge. hi/lo unchanged, done not pulsed.
  - Cancel and start in the same cycle: cancel wins, start ignored.
  - Cancel in IDLE: no effect.
  - Cancel on the final RUN cycle (counter==1): cancel wins, no commit.
- Arithmetic. Full 2*WIDTH product, with {hi,lo} = product. Signed ops use two's complement.
  - MULT/MULTU: signed/unsigned multiply.
  - DIV/DIVU: lo = quotient, hi = remainder. Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero (src_b==0): busy for DIV_CYCLES as normal, done pulses, hi/lo unchanged.
  - Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
- The result may be computed combinationally from the latched operands at commit, or iteratively. Only the commit timing above is architectural.
- done and busy are never both 1.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: op 111 = MADD. {hi,lo} = {hi,lo} + signed(src_a)*signed(src_b), modulo 2^(2*WIDTH). It uses the hi/lo value present at commit and has MULT_CYCLES latency.
- Undefined: op 111 treated as NOP. No accumulator adder is synthesised.

Test Plan:
- MULT, src_a=0xFFFFFFFE (-2), src_b=3, default params -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1 for one cycle.
- DIV, src_a=-7 (0xFFFFFFF9), src_b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with same operands -> lo=0x7FFFFFFC, hi=1.
- MTHI 0x12345678; DIV by 0 with src_a=5 -> hi stays 0x12345678, lo unchanged, done pulses after 10 cycles.
- MULTU 0xFFFFFFFF*0xFFFFFFFF, cancel asserted on busy cycle 3 -> busy drops next edge, no done pulse, hi/lo keep prior values; also check start+cancel in the same cycle is ignored.
- reset driven low mid-DIV (cycle 4) -> hi=lo=0, busy=0, done=0 immediately without a clock edge; a new MULT after reset release completes normally.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADD 1*1 -> hi=1, lo=0. Without the macro, op 111 -> no busy, hi/lo unchanged.

Source files
------------

// File: rtl/mdu_pipe_unit.sv
// Multiply/divide unit with architectural HI/LO, cancel and configurable latency.
// Define MDU_MADD_EN to enable op 111 as signed multiply-accumulate (MADD).
//
// state  | meaning
// S_IDLE | counter is zero; start is sampled, MTHI/MTLO write directly
// S_RUN  | multi-cycle op in flight; counter counts down to commit
module mdu_pipe_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0]    MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0]    DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0]    CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_MADD  = 3'd7
    } op_e;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e           state_q, state_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    op_e              op_q, op_n;
    logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
    logic [WIDTH-1:0] hi_q, hi_n, lo_q, lo_n;
    logic             busy_q, done_q, done_n;

    op_e op_in;
    assign op_in = op_e'(op);

    function automatic logic is_multi(input op_e o);
        logic m;
        m = (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
`ifdef MDU_MADD_EN
        m = m || (o == OP_MADD);
`endif
        return m;
    endfunction

    logic [2*WIDTH-1:0] prod_u, prod_s, result;
    logic [WIDTH-1:0]   b_safe, mag_a, mag_b, quo_m, rem_m, quo_s, rem_s;
    logic               is_div, div_zero;

    // Signed divide works on magnitudes so most-negative / -1 wraps to most-negative, remainder 0.
    always_comb begin
        is_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);
        div_zero = is_div && (b_q == '0);
        b_safe   = (b_q == '0) ? ONE : b_q;
        prod_u   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        prod_s   = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        mag_a    = a_q[WIDTH-1] ? (~a_q + ONE) : a_q;
        mag_b    = b_safe[WIDTH-1] ? (~b_safe + ONE) : b_safe;
        quo_m    = mag_a / mag_b;
        rem_m    = mag_a % mag_b;
        quo_s    = (a_q[WIDTH-1] ^ b_safe[WIDTH-1]) ? (~quo_m + ONE) : quo_m;
        rem_s    = a_q[WIDTH-1] ? (~rem_m + ONE) : rem_m;
        case (op_q)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   result = {rem_s, quo_s};
            OP_DIVU:  result = {a_q % b_safe, a_q / b_safe};
`ifdef MDU_MADD_EN
            OP_MADD:  result = {hi_q, lo_q} + prod_s;
`endif
            default:  result = {hi_q, lo_q};
        endcase
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        op_n    = op_q;
        a_n     = a_q;
        b_n     = b_q;
        hi_n    = hi_q;
        lo_n    = lo_q;
        done_n  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    if (is_multi(op_in)) begin
                        op_n    = op_in;
                        a_n     = src_a;
                        b_n     = src_b;
                        cnt_n   = ((op_in == OP_DIV) || (op_in == OP_DIVU)) ? DIV_LOAD : MULT_LOAD;
                        state_n = S_RUN;
                    end else if (op_in == OP_MTHI) begin
                        hi_n = src_a;
                    end else if (op_in == OP_MTLO) begin
                        lo_n = src_a;
                    end
                end
            end
            S_RUN: begin
                if (cancel) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                        if (!div_zero) begin
                            {hi_n, lo_n} = result;
                        end
                    end
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            op_q    <= op_n;
            a_q     <= a_n;
            b_q     <= b_n;
            hi_q    <= hi_n;
            lo_q    <= lo_n;
            busy_q  <= (state_n == S_RUN);
            done_q  <= done_n;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mdu_pipe_unit.sv
// Self-checking bench for mdu_pipe_unit: directed table, corner sequences, randomized ops vs. model.
module tb_mdu_pipe_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        cancel = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_pipe_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .cancel(cancel),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        logic [31:0] eh;
        logic [31:0] el;
        string       name;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                input int n, input logic [31:0] eh, input logic [31:0] el,
                                input string name);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.n = n; v.eh = eh; v.el = el; v.name = name;
        return v;
    endfunction

    // Reference arithmetic: returns {hi, lo} after the op given the current {hi, lo}.
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] cur);
        int          q, r;
        logic [63:0] p;
        case (o)
            3'd1: return 64'(longint'($signed(a)) * longint'($signed(b)));
            3'd2: return {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 32'd0) return cur;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            3'd4: begin
                if (b == 32'd0) return cur;
                return {a % b, a / b};
            end
            3'd7: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                return cur + p;
            end
            default: return cur;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic mc_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic [31:0] eh, input logic [31:0] el,
                         input string name);
        int cyc;
        bit both;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        cyc  = 0;
        both = 1'b0;
        while (busy === 1'b1 && cyc < 100) begin
            if (done !== 1'b0) both = 1'b1;
            cyc++;
            @(negedge clk);
        end
        check({name, " busy_cycles"}, 64'(cyc), 64'(n));
        check({name, " done_while_busy"}, {63'd0, both}, 64'd0);
        check({name, " done_pulse"}, {63'd0, done}, 64'd1);
        check({name, " hilo"}, {hi, lo}, {eh, el});
        @(negedge clk);
        check({name, " done_drop"}, {63'd0, done}, 64'd0);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] a, input string name);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = 32'h5A5A_5A5A;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        if (o == 3'd5) m_hi = a;
        else m_lo = a;
        check({name, " hilo"}, {hi, lo}, {m_hi, m_lo});
        check({name, " busy_done"}, {62'd0, busy, done}, 64'd0);
    endtask

    task automatic idle_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input string name);
        bit act;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        act = 1'b0;
        repeat (6) begin
            if (busy !== 1'b0 || done !== 1'b0) act = 1'b1;
            @(negedge clk);
        end
        check({name, " no_activity"}, {63'd0, act}, 64'd0);
        check({name, " hilo"}, {hi, lo}, {m_hi, m_lo});
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp;
        logic [2:0]  o;
        logic [31:0] a, b;
        bit          flag;

        vecs[0] = mk(3'd1, 32'hFFFF_FFFE, 32'd3,          5,  32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg");
        vecs[1] = mk(3'd3, 32'hFFFF_FFF9, 32'd2,          10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        vecs[2] = mk(3'd4, 32'hFFFF_FFF9, 32'd2,          10, 32'h0000_0001, 32'h7FFF_FFFC, "divu");
        vecs[3] = mk(3'd3, 32'h8000_0000, 32'hFFFF_FFFF,  10, 32'h0000_0000, 32'h8000_0000, "div_ovf");
        vecs[4] = mk(3'd1, 32'h8000_0000, 32'h8000_0000,  5,  32'h4000_0000, 32'h0000_0000, "mult_minmin");
        vecs[5] = mk(3'd3, 32'd7,         32'hFFFF_FFFE,  10, 32'h0000_0001, 32'hFFFF_FFFD, "div_negdivisor");
        vecs[6] = mk(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  5,  32'hFFFF_FFFE, 32'h0000_0001, "multu_max");

        #1;
        check("reset_state", {hi, lo, 30'd0, busy, done}, 96'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            mc_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].eh, vecs[i].el, vecs[i].name);
        end

        // divide by zero leaves hi/lo alone but still pulses done
        mt(3'd5, 32'h1234_5678, "mthi");
        mt(3'd6, 32'hABCD_EF01, "mtlo");
        mc_op(3'd3, 32'd5, 32'd0, 10, 32'h1234_5678, 32'hABCD_EF01, "div_by_zero");

        idle_op(3'd0, 32'h1111_1111, 32'h2222_2222, "nop");

        // cancel on busy cycle 3
        mt(3'd5, 32'hAAAA_5555, "mthi_pre_cancel");
        mt(3'd6, 32'h0F0F_0F0F, "mtlo_pre_cancel");
        @(negedge clk);
        start = 1'b1; op = 3'd2; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        repeat (2) @(negedge clk);
        check("cancel busy_before", {63'd0, busy}, 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel busy_after", {62'd0, busy, done}, 64'd0);
        flag = 1'b0;
        repeat (8) begin
            if (done !== 1'b0 || busy !== 1'b0) flag = 1'b1;
            @(negedge clk);
        end
        check("cancel no_done", {63'd0, flag}, 64'd0);
        check("cancel hilo", {hi, lo}, {m_hi, m_lo});

        // cancel on the final run cycle suppresses the commit
        @(negedge clk);
        start = 1'b1; op = 3'd1; src_a = 32'd3; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        repeat (4) @(negedge clk);
        check("cancel_last busy_before", {63'd0, busy}, 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_last busy_done", {62'd0, busy, done}, 64'd0);
        check("cancel_last hilo", {hi, lo}, {m_hi, m_lo});

        // start together with cancel is ignored
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 3'd1; src_a = 32'd3; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0; op = 3'd0;
        flag = 1'b0;
        repeat (7) begin
            if (done !== 1'b0 || busy !== 1'b0) flag = 1'b1;
            @(negedge clk);
        end
        check("start_cancel no_activity", {63'd0, flag}, 64'd0);
        check("start_cancel hilo", {hi, lo}, {m_hi, m_lo});

        // asynchronous reset on busy cycle 4 of a DIV
        @(negedge clk);
        start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        repeat (3) @(negedge clk);
        check("reset_mid busy_before", {63'd0, busy}, 64'd1);
        #2 reset = 1'b0;
        #1;
        check("reset_mid state", {hi, lo, 30'd0, busy, done}, 96'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        mc_op(3'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42, "mult_after_reset");

`ifdef MDU_MADD_EN
        mt(3'd5, 32'd0, "mthi_madd");
        mt(3'd6, 32'hFFFF_FFFF, "mtlo_madd");
        mc_op(3'd7, 32'd1, 32'd1, 5, 32'd1, 32'd0, "madd_carry");
`else
        idle_op(3'd7, 32'd1, 32'd1, "op7_nop");
`endif

        for (int i = 0; i < 40; i++) begin
`ifdef MDU_MADD_EN
            o = 3'($urandom_range(1, 7));
`else
            o = 3'($urandom_range(1, 6));
`endif
            a = pick_val();
            b = pick_val();
            if (o == 3'd5 || o == 3'd6) begin
                mt(o, a, "rand_mt");
            end else begin
                exp = ref_model(o, a, b, {m_hi, m_lo});
                mc_op(o, a, b, (o == 3'd3 || o == 3'd4) ? 10 : 5, exp[63:32], exp[31:0], "rand_md");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
